// File: rtl/cnn_scan_pkg.sv
// cnn_scan_pkg: shared scan-loader state encoding and default geometry
package cnn_scan_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, RDREQ, RDCAP} state_e;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/scan_sync_edge.sv
// scan_sync_edge: multi-flop pad synchronizer with a one-cycle delayed copy for edge detection
module scan_sync_edge
    import cnn_scan_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_signal_ext,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic dly_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;

    // shift the pad value down the chain; the delayed copy trails the last stage by one cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        dly_d  = sync_q[STAGES-1];
    end

    // synchronizer and delay flops
    always_ff @(posedge clk_signal_ext or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign dly_o  = dly_q;

endmodule

// File: rtl/scan_weight_loader.sv
// scan_weight_loader: serial scan port to SRAM bridge (scan-in writes, scan-out reads)
module scan_weight_loader
    import cnn_scan_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk_signal_ext,
    input  logic              rst_n,
    input  logic              phi,
    input  logic              phib,
    input  logic              scan_i0o1,
    input  logic              load,
    input  logic              scan_in,
    input  logic              write_en,
    output logic              scan_out,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              frame_err,
    output logic              ovl_err
);

    localparam int              CW   = $clog2(DATA_W + 2);
    localparam logic [CW-1:0]   FULL = CW'(DATA_W);
    localparam logic [CW-1:0]   OVR  = CW'(DATA_W + 1);

    logic phi_s, phi_dl, load_s, load_dl, mode_s, mode_dl;

    scan_sync_edge #(.STAGES(SYNC_STAGES)) u_phi (
        .clk_signal_ext(clk_signal_ext), .rst_n(rst_n), .d_i(phi), .sync_o(phi_s), .dly_o(phi_dl)
    );
    scan_sync_edge #(.STAGES(SYNC_STAGES)) u_load (
        .clk_signal_ext(clk_signal_ext), .rst_n(rst_n), .d_i(load), .sync_o(load_s), .dly_o(load_dl)
    );
    scan_sync_edge #(.STAGES(SYNC_STAGES)) u_mode (
        .clk_signal_ext(clk_signal_ext), .rst_n(rst_n), .d_i(scan_i0o1), .sync_o(mode_s), .dly_o(mode_dl)
    );

    logic [2:0][SYNC_STAGES-1:0] psync_q, psync_d;
    logic                        phib_s, scan_in_s, wen_s;

    // level-only pads: phib, scan_in, write_en
    always_comb begin
        psync_d[0] = {psync_q[0][SYNC_STAGES-2:0], phib};
        psync_d[1] = {psync_q[1][SYNC_STAGES-2:0], scan_in};
        psync_d[2] = {psync_q[2][SYNC_STAGES-2:0], write_en};
    end

    assign phib_s    = psync_q[0][SYNC_STAGES-1];
    assign scan_in_s = psync_q[1][SYNC_STAGES-1];
    assign wen_s     = psync_q[2][SYNC_STAGES-1];

    logic phi_ev_q, phi_ev_d, load_ev_q, load_ev_d, chg_ev_q, chg_ev_d;

    // edge pulses are registered so the FSM sees a clean one-cycle event; phi is vetoed while phib is high
    always_comb begin
        phi_ev_d  = phi_s & ~phi_dl & ~phib_s;
        load_ev_d = load_s & ~load_dl;
        chg_ev_d  = mode_s ^ mode_dl;
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d, base_cnt;
    logic [ADDR_W-1:0] addr_q, addr_d, base_addr, mem_addr_q, mem_addr_d;
    logic              pend_q, pend_d, mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic              ferr_q, ferr_d, ovl_q, ovl_d, idle, clr;

    // frame FSM: shifting and commit decisions in IDLE, single-cycle memory states otherwise;
    // a mode change seen mid-transaction is remembered and applied on return to IDLE
    always_comb begin
        idle        = state_q == IDLE;
        clr         = idle && (chg_ev_q || pend_q);
        base_addr   = clr ? '0 : addr_q;
        base_cnt    = clr ? '0 : cnt_q;
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        pend_d      = pend_q | chg_ev_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ferr_d      = ferr_q | (!idle && (phi_ev_q || load_ev_q)) | (idle && load_ev_q && phi_ev_q)
                    | (idle && load_ev_q && !mode_s && base_cnt != FULL);
        ovl_d       = ovl_q | (phi_s & phib_s);
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                addr_d = base_addr;
                cnt_d  = base_cnt;
                if (load_ev_q && !mode_s) begin
                    cnt_d = '0;
                    if (base_cnt == FULL && wen_s) begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = shift_q;
                        mem_addr_d  = base_addr;
                        addr_d      = base_addr + ADDR_W'(1);
                    end
                end else if (load_ev_q) begin
                    state_d    = RDREQ;
                    mem_re_d   = 1'b1;
                    mem_addr_d = base_addr;
                    addr_d     = base_addr + ADDR_W'(1);
                end else if (phi_ev_q) begin
                    shift_d = {shift_q[DATA_W-2:0], mode_s ? 1'b0 : scan_in_s};
                    cnt_d   = (mode_s || base_cnt == OVR) ? base_cnt : base_cnt + CW'(1);
                end
            end
            WRITE:   state_d = IDLE;
            RDREQ:   state_d = RDCAP;
            default: begin
                shift_d = mem_rdata;
                state_d = IDLE;
            end
        endcase
    end

    // all state, event and output registers
    always_ff @(posedge clk_signal_ext or negedge rst_n) begin
        if (!rst_n) begin
            psync_q     <= '0;
            phi_ev_q    <= 1'b0;
            load_ev_q   <= 1'b0;
            chg_ev_q    <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ferr_q      <= 1'b0;
            ovl_q       <= 1'b0;
        end else begin
            psync_q     <= psync_d;
            phi_ev_q    <= phi_ev_d;
            load_ev_q   <= load_ev_d;
            chg_ev_q    <= chg_ev_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ferr_q      <= ferr_d;
            ovl_q       <= ovl_d;
        end
    end

    assign scan_out  = shift_q[DATA_W-1];
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign frame_err = ferr_q;
    assign ovl_err   = ovl_q;

endmodule

// File: tb/tb_scan_weight_loader.sv
// tb_scan_weight_loader: directed scenario bench for the scan weight loader
module tb_scan_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n, phi, phib, scan_i0o1, load, scan_in, write_en;
    logic        scan_out, mem_we, mem_re, frame_err, ovl_err;
    logic [1:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] mem_model [4];

    logic [1:0]  we_addr[$];
    logic [15:0] we_data[$];
    logic [1:0]  re_addr[$];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    scan_weight_loader #(.DATA_W(16), .ADDR_W(2), .SYNC_STAGES(2)) dut (
        .clk_signal_ext(clk), .rst_n(rst_n), .phi(phi), .phib(phib), .scan_i0o1(scan_i0o1),
        .load(load), .scan_in(scan_in), .write_en(write_en), .scan_out(scan_out),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .frame_err(frame_err), .ovl_err(ovl_err)
    );

    // SRAM model with one-cycle read latency
    always @(posedge clk) if (mem_re) mem_rdata <= mem_model[mem_addr];

    // log every memory strobe away from the active edge
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
        end
        if (rst_n && mem_re) re_addr.push_back(mem_addr);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        we_addr.delete();
        we_data.delete();
        re_addr.delete();
    endtask

    task automatic shift_bit(input logic b);
        scan_in = b;
        cyc(2);
        phi = 1'b1;
        cyc(4);
        phi = 1'b0;
        cyc(4);
    endtask

    task automatic shift_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        cyc(4);
        load = 1'b0;
        cyc(8);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        phi       = 1'b0;
        phib      = 1'b0;
        load      = 1'b0;
        scan_in   = 1'b0;
        scan_i0o1 = 1'b0;
        write_en  = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        phi       = 1'b0;
        phib      = 1'b0;
        load      = 1'b0;
        scan_in   = 1'b0;
        scan_i0o1 = 1'b0;
        write_en  = 1'b1;
        cyc(3);
        total++;
        if ({scan_out, mem_we, mem_re, mem_addr, mem_wdata, frame_err, ovl_err} !== 22'h0)
            $display("FAIL reset_outputs got %h want 0",
                     {scan_out, mem_we, mem_re, mem_addr, mem_wdata, frame_err, ovl_err});
        else pass_cnt++;
        rst_n = 1'b1;
        cyc(3);
        clear_logs();
    endtask

    task automatic test_write();
        shift_word(16'hA5C3);
        pulse_load();
        total++;
        if (we_addr.size() !== 1) $display("FAIL write_count got %0d want 1", we_addr.size());
        else pass_cnt++;
        if (we_addr.size() > 0) begin
            total++;
            if (we_addr[0] !== 2'd0) $display("FAIL write_addr got %0d want 0", we_addr[0]);
            else pass_cnt++;
            total++;
            if (we_data[0] !== 16'hA5C3) $display("FAIL write_data got %h want a5c3", we_data[0]);
            else pass_cnt++;
        end
        total++;
        if (frame_err !== 1'b0) $display("FAIL write_frame_err got %b want 0", frame_err);
        else pass_cnt++;
    endtask

    task automatic test_readback();
        logic [15:0] got;
        got = '0;
        clear_logs();
        mem_model[0] = 16'h1234;
        scan_i0o1 = 1'b1;
        cyc(8);
        pulse_load();
        total++;
        if (re_addr.size() !== 1) $display("FAIL read_count got %0d want 1", re_addr.size());
        else pass_cnt++;
        if (re_addr.size() > 0) begin
            total++;
            if (re_addr[0] !== 2'd0) $display("FAIL read_addr got %0d want 0", re_addr[0]);
            else pass_cnt++;
        end
        for (int i = 15; i >= 0; i--) begin
            got[i] = scan_out;
            shift_bit(1'b0);
        end
        total++;
        if (got !== 16'b0001_0010_0011_0100) $display("FAIL read_serial got %b want 0001001000110100", got);
        else pass_cnt++;
        total++;
        if (we_addr.size() !== 0) $display("FAIL read_no_write got %0d want 0", we_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_frame_errors();
        do_reset();
        for (int i = 0; i < 15; i++) shift_bit(i[0]);
        pulse_load();
        total++;
        if (we_addr.size() !== 0) $display("FAIL short_frame_write got %0d want 0", we_addr.size());
        else pass_cnt++;
        total++;
        if (frame_err !== 1'b1) $display("FAIL short_frame_err got %b want 1", frame_err);
        else pass_cnt++;
        do_reset();
        total++;
        if (frame_err !== 1'b0) $display("FAIL err_cleared got %b want 0", frame_err);
        else pass_cnt++;
        for (int i = 0; i < 17; i++) shift_bit(i[0]);
        pulse_load();
        total++;
        if (we_addr.size() !== 0) $display("FAIL long_frame_write got %0d want 0", we_addr.size());
        else pass_cnt++;
        total++;
        if (frame_err !== 1'b1) $display("FAIL long_frame_err got %b want 1", frame_err);
        else pass_cnt++;
    endtask

    task automatic test_overlap();
        logic [7:0] a, b;
        a = 8'hA5;
        b = 8'h3C;
        do_reset();
        for (int i = 7; i >= 0; i--) shift_bit(a[i]);
        scan_in = 1'b1;
        phi     = 1'b1;
        phib    = 1'b1;
        cyc(3);
        phi  = 1'b0;
        phib = 1'b0;
        cyc(4);
        total++;
        if (ovl_err !== 1'b1) $display("FAIL ovl_err got %b want 1", ovl_err);
        else pass_cnt++;
        for (int i = 7; i >= 0; i--) shift_bit(b[i]);
        pulse_load();
        total++;
        if (we_addr.size() !== 1) $display("FAIL ovl_write_count got %0d want 1", we_addr.size());
        else pass_cnt++;
        if (we_data.size() > 0) begin
            total++;
            if (we_data[0] !== 16'hA53C) $display("FAIL ovl_shift_data got %h want a53c", we_data[0]);
            else pass_cnt++;
        end
        total++;
        if (frame_err !== 1'b0) $display("FAIL ovl_frame_err got %b want 0", frame_err);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [1:0]  exp_a [5];
        logic [15:0] exp_d [5];
        exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d = '{16'h1111, 16'h2222, 16'h4444, 16'h8888, 16'hF00F};
        do_reset();
        for (int f = 0; f < 5; f++) begin
            shift_word(exp_d[f]);
            pulse_load();
        end
        total++;
        if (we_addr.size() !== 5) $display("FAIL wrap_count got %0d want 5", we_addr.size());
        else pass_cnt++;
        for (int f = 0; f < 5 && f < we_addr.size(); f++) begin
            total++;
            if (we_addr[f] !== exp_a[f] || we_data[f] !== exp_d[f])
                $display("FAIL wrap_frame%0d got %0d/%h want %0d/%h", f, we_addr[f], we_data[f], exp_a[f], exp_d[f]);
            else pass_cnt++;
        end
        write_en = 1'b0;
        cyc(4);
        shift_word(16'h5555);
        pulse_load();
        total++;
        if (we_addr.size() !== 5) $display("FAIL wen_drop_count got %0d want 5", we_addr.size());
        else pass_cnt++;
        total++;
        if (frame_err !== 1'b0) $display("FAIL wen_drop_err got %b want 0", frame_err);
        else pass_cnt++;
        write_en = 1'b1;
        cyc(4);
        shift_word(16'h6666);
        pulse_load();
        total++;
        if (we_addr.size() !== 6 || we_addr[we_addr.size()-1] !== 2'd1)
            $display("FAIL wen_addr_held got %0d writes last addr %0d want 6 writes addr 1",
                     we_addr.size(), we_addr[we_addr.size()-1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        shift_word(16'h0F0F);
        pulse_load();
        phi  = 1'b1;
        phib = 1'b1;
        cyc(3);
        phi  = 1'b0;
        phib = 1'b0;
        cyc(4);
        for (int i = 0; i < 8; i++) shift_bit(1'b1);
        rst_n = 1'b0;
        cyc(2);
        total++;
        if ({scan_out, mem_we, mem_re, mem_addr, mem_wdata, frame_err, ovl_err} !== 22'h0)
            $display("FAIL midreset_outputs got %h want 0",
                     {scan_out, mem_we, mem_re, mem_addr, mem_wdata, frame_err, ovl_err});
        else pass_cnt++;
        total++;
        if (we_addr.size() !== 1) $display("FAIL midreset_no_partial got %0d want 1", we_addr.size());
        else pass_cnt++;
        rst_n = 1'b1;
        cyc(3);
        clear_logs();
        shift_word(16'hBEEF);
        pulse_load();
        total++;
        if (we_addr.size() !== 1 || we_addr[0] !== 2'd0 || we_data[0] !== 16'hBEEF)
            $display("FAIL midreset_refill got %0d writes %0d/%h want 1 write 0/beef",
                     we_addr.size(), we_addr[0], we_data[0]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_frame_errors();
        test_overlap();
        test_wrap();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
